// File: rtl/dmem_bytelane_if.sv
// Load/store and clear-control bus between the core (master) and the
// byte-lane data memory (slave).
interface dmem_bytelane_if;
  logic        we;
  logic        re;
  logic [2:0]  funct3;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] ReadData;
  logic        clr_req;
  logic        busy;
  logic        misalign;
  logic        fault;

  modport master (
    output we, re, funct3, A, WD, clr_req,
    input  ReadData, busy, misalign, fault
  );

  modport slave (
    input  we, re, funct3, A, WD, clr_req,
    output ReadData, busy, misalign, fault
  );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory for the single-cycle RISC-V core.
// Sub-word loads with sign/zero extension, byte-lane stores, and a clear
// engine that zeroes one word per cycle. Reads are combinational.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to detect misaligned
// accesses, suppress misaligned stores and keep a sticky fault flag.
module dmem_bytelane #(
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  dmem_bytelane_if.slave   bus
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [31:0]     mem_q [DEPTH];

  logic [IW-1:0]   word_idx;
  logic [1:0]      size;
  logic [1:0]      boff;
  logic            busy;
  logic            mis;
  logic            clr_wr;
  logic [3:0]      st_be;
  logic [31:0]     st_data;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  assign word_idx = bus.A[IW+1:2];
  assign size     = bus.funct3[1:0];
  assign boff     = bus.A[1:0];
  assign busy     = (state_q == S_CLEAR);
  assign bus.busy = busy;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign mis = ((size == 2'b01) && bus.A[0]) ||
               ((size == 2'b10) && (bus.A[1:0] != 2'b00));

  // Sticky fault: any load or store strobe on a misaligned address, busy or not.
  always_comb begin
    fault_d = fault_q | ((bus.we | bus.re) & mis);
  end

  // Fault register; reset takes priority over a same-edge fault event.
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign bus.fault = fault_q;

  logic unused_addr;
  assign unused_addr = ^bus.A[31:IW+2];
`else
  assign mis       = 1'b0;
  assign bus.fault = 1'b0;

  logic unused_sigs;
  assign unused_sigs = ^{bus.A[31:IW+2], bus.re};
`endif

  assign bus.misalign = mis;

  // Store lane enables and lane-replicated data; nothing is written while busy.
  always_comb begin
    st_be   = 4'b0000;
    st_data = bus.WD;
    unique case (size)
      2'b00: begin
        st_be[boff] = 1'b1;
        st_data     = {4{bus.WD[7:0]}};
      end
      2'b01: begin
        st_be[{bus.A[1], 1'b0}] = 1'b1;
        st_be[{bus.A[1], 1'b1}] = 1'b1;
        st_data                 = {2{bus.WD[15:0]}};
      end
      2'b10:   st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
    if (!(bus.we && !busy && !mis)) st_be = 4'b0000;
  end

  // A clear write is squashed by reset so an aborted clear leaves the current word intact.
  assign clr_wr = busy && !reset;

  // Memory array: clear engine writes whole words, CPU stores write enabled lanes.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (st_be[l]) mem_q[word_idx][8*l +: 8] <= st_data[8*l +: 8];
      end
    end
  end

  // Clear engine next state: start from idle on request, walk every word once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == IW'(DEPTH - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear engine state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Combinational load path with lane select and extension; forced to zero while clearing.
  always_comb begin
    rd_word = mem_q[word_idx];
    rd_byte = rd_word[{boff, 3'b000} +: 8];
    rd_half = rd_word[{bus.A[1], 4'b0000} +: 16];
    unique case (bus.funct3)
      3'b000:  bus.ReadData = sext8(rd_byte);
      3'b001:  bus.ReadData = sext16(rd_half);
      3'b100:  bus.ReadData = {24'b0, rd_byte};
      3'b101:  bus.ReadData = {16'b0, rd_half};
      default: bus.ReadData = rd_word;
    endcase
    if (busy) bus.ReadData = '0;
  end
endmodule
